// File: rtl/sting_weight_buf.sv
// Double-buffered kernel/BN weight staging buffer: fills one bank from the
// kernel and BN word streams while the other bank is presented downstream.
module sting_weight_buf #(
    parameter int DW       = 32,
    parameter int KSIZE    = 3,
    parameter int BN_WORDS = 2,
    parameter int CH_W     = 10
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic                     start,
    input  logic [CH_W-1:0]          ch_num,
    output logic                     busy,
    output logic                     done,
    input  logic                     w_valid,
    input  logic [DW-1:0]            w_data,
    output logic                     w_ready,
    input  logic                     b_valid,
    input  logic [DW-1:0]            b_data,
    output logic                     b_ready,
    output logic                     out_ready,
    input  logic                     out_next,
    output logic [KSIZE*KSIZE*DW-1:0] out_weight,
    output logic [BN_WORDS*DW-1:0]   out_bn,
    output logic [CH_W-1:0]          out_ch
);

    localparam int NK  = KSIZE * KSIZE;
    localparam int WCW = (NK > 1) ? $clog2(NK) : 1;
    localparam int BCW = (BN_WORDS > 1) ? $clog2(BN_WORDS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_FILL_W, S_FILL_B} fill_state_t;

    fill_state_t     state, state_nx;
    logic [DW-1:0]   kmem [2][NK];
    logic [DW-1:0]   bmem [2][BN_WORDS];
    logic [1:0]      full;
    logic            fb, rb;
    logic            commit_pend, commit_bank;
    logic [CH_W-1:0] ch_num_r, filled, consumed;
    logic [WCW-1:0]  wcnt;
    logic [BCW-1:0]  bcnt;
    logic            fill_ok, w_acc, b_acc, w_last, b_last, consume;

    assign fill_ok = busy && !full[fb] && (filled < ch_num_r);
    assign w_acc   = w_valid && w_ready;
    assign b_acc   = b_valid && b_ready;
    assign w_last  = (wcnt == WCW'(NK - 1));
    assign b_last  = (bcnt == BCW'(BN_WORDS - 1));
    assign out_ready = full[rb];
    assign consume = out_next && out_ready;

    always_ff @(posedge aclk) begin
        if (areset) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   if (fill_ok) state_nx = S_FILL_W;
            S_FILL_W: if (w_acc && w_last) state_nx = S_FILL_B;
            S_FILL_B: if (b_acc && b_last) state_nx = S_IDLE;
            default:  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        w_ready = (state == S_FILL_W) && fill_ok;
        b_ready = (state == S_FILL_B) && fill_ok;
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            full        <= '0;
            fb          <= 1'b0;
            rb          <= 1'b0;
            commit_pend <= 1'b0;
            commit_bank <= 1'b0;
            ch_num_r    <= '0;
            filled      <= '0;
            consumed    <= '0;
            wcnt        <= '0;
            bcnt        <= '0;
            out_ch      <= '0;
            for (int unsigned b = 0; b < 2; b++) begin
                for (int unsigned i = 0; i < NK; i++) kmem[b][i] <= '0;
                for (int unsigned j = 0; j < BN_WORDS; j++) bmem[b][j] <= '0;
            end
        end else begin
            done <= 1'b0;
            if (start && !busy) begin
                ch_num_r <= ch_num;
                filled   <= '0;
                consumed <= '0;
                if (ch_num != '0) busy <= 1'b1;
                else              done <= 1'b1;
            end
            if (w_acc) begin
                kmem[fb][wcnt] <= w_data;
                wcnt <= w_last ? '0 : wcnt + 1'b1;
            end
            // A completed bank is published one cycle after its last BN word.
            if (commit_pend) begin
                commit_pend       <= 1'b0;
                full[commit_bank] <= 1'b1;
            end
            if (b_acc) begin
                bmem[fb][bcnt] <= b_data;
                if (b_last) begin
                    bcnt        <= '0;
                    fb          <= ~fb;
                    filled      <= filled + 1'b1;
                    commit_pend <= 1'b1;
                    commit_bank <= fb;
                end else begin
                    bcnt <= bcnt + 1'b1;
                end
            end
            if (consume) begin
                full[rb] <= 1'b0;
                rb       <= ~rb;
                out_ch   <= out_ch + 1'b1;
                consumed <= consumed + 1'b1;
                if (consumed + 1'b1 == ch_num_r) begin
                    done <= 1'b1;
                    busy <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        out_weight = '0;
        out_bn     = '0;
        for (int unsigned i = 0; i < NK; i++) out_weight[i*DW +: DW] = kmem[rb][i];
        for (int unsigned j = 0; j < BN_WORDS; j++) out_bn[j*DW +: DW] = bmem[rb][j];
    end

endmodule
